pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Duty-cycle sequencer that sits in front of the 9-bit-duty PWM generator and drives its duty input. It accepts a target duty over a valid/ready handshake. It then ramps the applied duty toward that target in programmable steps, and applies each change only on a PWM period boundary (soft-start / soft-stop). It also provides an abort path that forces the output to 0% immediately.

Parameters:
DUTY_W, 9, width of duty values; matches the PWM duty input.
MAX_DUTY, 256, largest legal duty (100% for a 256-count PWM period); larger targets are clamped to this.
PERIODS_PER_STEP, 4, number of PWM periods between successive duty updates; must be ≥1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
period_strobe  input  1  one-cycle pulse marking the start of each PWM period (PWM duty counter wrap)
target_duty  input  DUTY_W  requested final duty
step_size  input  8  duty increment per update; sampled together with target_duty
target_valid  input  1  request qualifier
target_ready  output  1  controller can accept a request
abort  input  1  emergency stop
duty_out  output  DUTY_W  registered duty fed to the PWM generator
busy  output  1  high while in RAMP_UP or RAMP_DOWN
done  output  1  one-cycle pulse when the target is reached

Behaviour:
- Reset (synchronous): state=IDLE, duty_out=0, busy=0, done=0, period_cnt=0, latched target=0, latched step=1.
- target_ready = (state==IDLE) && !abort. It is combinational from state and abort.
- Acceptance happens on a cycle with target_valid && target_ready. On that cycle:
  - latch tgt = min(target_duty, MAX_DUTY);
  - latch stp = max(step_size, 1); a step of 0 is treated as 1;
  - clear period_cnt.
- Next state after acceptance:
  - tgt > duty_out → RAMP_UP.
  - tgt < duty_out → RAMP_DOWN.
  - tgt == duty_out → remain IDLE and pulse done on the next cycle.
- States are IDLE, RAMP_UP and RAMP_DOWN; busy=1 only in the RAMP states.
- Update timing in a RAMP state: on each period_strobe, if period_cnt==PERIODS_PER_STEP-1, update duty_out on the next clock edge and clear period_cnt; otherwise increment period_cnt.
- Update arithmetic uses DUTY_W+1 bits, so results never wrap:
  - UP: duty_out ← min(duty_out+stp, tgt).
  - DOWN: duty_out ← max(duty_out−stp, tgt); the subtraction saturates at 0 before the compare.
- When an update makes duty_out equal tgt: go to IDLE and pulse done for 1 cycle, aligned with the first cycle that shows the final duty_out. target_ready rises in that same cycle.
- duty_out changes only in the cycle after a period_strobe, or because of reset or abort. It never changes mid-period during a ramp.
- period_strobe in IDLE is ignored, and period_cnt holds at 0.
- First-update latency after acceptance is exactly PERIODS_PER_STEP strobes.
- abort has the highest priority after reset. On the next edge: duty_out=0, state=IDLE, period_cnt=0, done not pulsed. A request on the same cycle as abort is not accepted. abort held high keeps duty_out=0 and target_ready=0.
- Requests are not accepted while a ramp is in progress (target_ready=0); the requester must hold target_valid until ready.
- Reset mid-ramp returns every register to its reset value on the next edge, regardless of other inputs.

Test Plan:
1. Reset, then target 128, step 32, strobe every 10 clocks → duty_out 0→32→64→96→128, changing after strobes 4, 8, 12 and 16; done pulses once with duty_out=128; busy falls in the same cycle.
2. From duty 128, target 0, step 50 → 78, 28, 0 (saturated); done once; no wrap to a large value.
3. Target 300, step 255 from 0 → target clamped; duty_out 255 then 256; done with duty_out=256.
4. Target 100 while duty_out=100 → no busy; done pulses 1 cycle after acceptance; duty_out unchanged.
5. Mid-ramp at duty 64, assert abort together with target_valid → duty_out=0 next cycle, no done, request not accepted; after abort drops, target_ready=1.
6. step_size 0, target 3 → three updates 1, 2, 3. Then, with reset asserted mid-ramp, all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer for a PWM generator: accepts a target duty, then ramps the
// applied duty toward it in fixed steps, updating only on PWM period boundaries.
module pwm_ramp_ctrl #(
    parameter int unsigned DUTY_W           = 9,
    parameter int unsigned MAX_DUTY         = 256,
    parameter int unsigned PERIODS_PER_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              period_strobe,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic [7:0]        step_size,
    input  logic              target_valid,
    output logic              target_ready,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      CNT_W    = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(MAX_DUTY);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIODS_PER_STEP - 1);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } state_t;

    state_t state, state_next;

    logic [DUTY_W-1:0] tgt;
    logic [7:0]        stp;
    logic [CNT_W-1:0]  period_cnt;

    logic [DUTY_W-1:0] tgt_in;
    logic [7:0]        stp_in;
    logic [DUTY_W:0]   wide_duty;
    logic [DUTY_W:0]   wide_tgt;
    logic [DUTY_W:0]   wide_stp;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   dn_diff;
    logic [DUTY_W-1:0] stepped_duty;
    logic              accept;
    logic              step_due;
    logic              reached;

    // Request conditioning and one-bit-wider step arithmetic so neither direction wraps.
    always_comb begin
        tgt_in    = (target_duty > MAX_D) ? MAX_D : target_duty;
        stp_in    = (step_size == '0) ? 8'd1 : step_size;
        wide_duty = {1'b0, duty_out};
        wide_tgt  = {1'b0, tgt};
        wide_stp  = (DUTY_W + 1)'(stp);
        up_sum    = wide_duty + wide_stp;
        dn_diff   = (wide_duty > wide_stp) ? (wide_duty - wide_stp) : '0;
        if (state == RAMP_UP) begin
            stepped_duty = (up_sum > wide_tgt) ? tgt : up_sum[DUTY_W-1:0];
        end else begin
            stepped_duty = (dn_diff < wide_tgt) ? tgt : dn_diff[DUTY_W-1:0];
        end
        accept   = target_valid && target_ready;
        step_due = (state != IDLE) && period_strobe && (period_cnt == CNT_LAST);
        reached  = step_due && (stepped_duty == tgt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (tgt_in > duty_out) begin
                            state_next = RAMP_UP;
                        end else if (tgt_in < duty_out) begin
                            state_next = RAMP_DOWN;
                        end
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (reached) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        target_ready = (state == IDLE) && !abort;
        busy         = (state != IDLE);
    end

    // done is registered on the same edge that loads the final duty, so both appear together.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_out   <= '0;
            done       <= 1'b0;
            period_cnt <= '0;
            tgt        <= '0;
            stp        <= 8'd1;
        end else if (abort) begin
            duty_out   <= '0;
            done       <= 1'b0;
            period_cnt <= '0;
        end else begin
            done <= (accept && (tgt_in == duty_out)) || reached;
            if (accept) begin
                tgt        <= tgt_in;
                stp        <= stp_in;
                period_cnt <= '0;
            end else if ((state != IDLE) && period_strobe) begin
                if (step_due) begin
                    duty_out   <= stepped_duty;
                    period_cnt <= '0;
                end else begin
                    period_cnt <= period_cnt + CNT_W'(1);
                end
            end else if (state == IDLE) begin
                period_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: a scoreboard of expected duty updates
// (value and strobe index) is filled per request and drained by a duty monitor.
module tb_pwm_ramp_ctrl;

    localparam int PPS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       period_strobe;
    logic [8:0] target_duty;
    logic [7:0] step_size;
    logic       target_valid;
    logic       target_ready;
    logic       abort;
    logic [8:0] duty_out;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(
        .DUTY_W          (9),
        .MAX_DUTY        (256),
        .PERIODS_PER_STEP(PPS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .period_strobe(period_strobe),
        .target_duty  (target_duty),
        .step_size    (step_size),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .abort        (abort),
        .duty_out     (duty_out),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        int duty;
        int strobe;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t push_e;

    int tests_run    = 0;
    int tests_failed = 0;
    int strobe_cnt   = 0;
    int done_cnt     = 0;
    int pop_cnt      = 0;
    int model_duty   = 0;
    int exp_final    = 0;
    int d0;
    int p0;

    logic       mon_en = 1'b0;
    logic [8:0] prev_duty;
    logic       prev_strobe = 1'b0;
    logic       prev_done   = 1'b0;

    task automatic check(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (duty_out !== prev_duty) begin
                if (sb.size() == 0) begin
                    check("unexpected_change", int'(duty_out), int'(prev_duty));
                end else begin
                    mon_e = sb.pop_front();
                    pop_cnt++;
                    check("duty", int'(duty_out), mon_e.duty);
                    if (mon_e.strobe >= 0) begin
                        check("strobe_no", strobe_cnt, mon_e.strobe);
                        check("after_strobe", int'(prev_strobe), 1);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                check("done_duty", int'(duty_out), exp_final);
                check("done_busy", int'(busy), 0);
                check("done_ready", int'(target_ready), 1);
                check("done_width", int'(prev_done), 0);
            end
            prev_duty   = duty_out;
            prev_strobe = period_strobe;
            prev_done   = done;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_period();
        period_strobe = 1'b1;
        strobe_cnt++;
        cyc();
        period_strobe = 1'b0;
        repeat (9) cyc();
    endtask

    task automatic run_ramp(input int want_done, input int want_pops, input int max_periods);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_periods; i++) begin
            if ((want_done >= 0 && done_cnt >= want_done) || (want_pops >= 0 && pop_cnt >= want_pops)) begin
                ok = 1'b1;
                break;
            end
            strobe_period();
        end
        if ((want_done >= 0 && done_cnt >= want_done) || (want_pops >= 0 && pop_cnt >= want_pops)) ok = 1'b1;
        check("ramp_complete", int'(ok), 1);
    endtask

    // Builds the expected update sequence independently, then performs the handshake.
    task automatic request(input int target, input int step, input bit expect_ramp);
        int tgt;
        int s;
        int d;
        int n;
        int waited;
        tgt = (target > 256) ? 256 : target;
        s   = (step == 0) ? 1 : step;
        d   = model_duty;
        n   = 0;
        while (d != tgt) begin
            n += PPS;
            if (tgt > d) begin
                d = (d + s > tgt) ? tgt : d + s;
            end else begin
                d = (d - s < 0) ? 0 : d - s;
                if (d < tgt) d = tgt;
            end
            push_e.duty   = d;
            push_e.strobe = n;
            sb.push_back(push_e);
        end
        exp_final    = tgt;
        model_duty   = tgt;
        target_duty  = 9'(target);
        step_size    = 8'(step);
        target_valid = 1'b1;
        strobe_cnt   = 0;
        waited       = 0;
        while (!target_ready && waited < 50) begin
            cyc();
            waited++;
        end
        check("ready_wait", int'(target_ready), 1);
        cyc();
        target_valid = 1'b0;
        check("accept_busy", int'(busy), int'(expect_ramp));
        check("accept_ready", int'(target_ready), int'(!expect_ramp));
    endtask

    initial begin
        reset         = 1'b1;
        period_strobe = 1'b0;
        target_duty   = '0;
        step_size     = '0;
        target_valid  = 1'b0;
        abort         = 1'b0;
        repeat (3) cyc();
        check("rst_duty", int'(duty_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(target_ready), 1);
        reset     = 1'b0;
        prev_duty = duty_out;
        mon_en    = 1'b1;
        cyc();

        // Ramp up 0 -> 128 in steps of 32.
        d0 = done_cnt;
        request(128, 32, 1'b1);
        run_ramp(d0 + 1, -1, 30);
        check("t1_sb_empty", sb.size(), 0);
        check("t1_done_cnt", done_cnt, d0 + 1);

        // Ramp down 128 -> 0 with saturation at zero.
        d0 = done_cnt;
        request(0, 50, 1'b1);
        run_ramp(d0 + 1, -1, 30);
        check("t2_sb_empty", sb.size(), 0);
        check("t2_duty", int'(duty_out), 0);
        check("t2_done_cnt", done_cnt, d0 + 1);

        // Oversized target clamps to full scale.
        d0 = done_cnt;
        request(300, 255, 1'b1);
        run_ramp(d0 + 1, -1, 30);
        check("t3_sb_empty", sb.size(), 0);
        check("t3_duty", int'(duty_out), 256);

        d0 = done_cnt;
        request(100, 156, 1'b1);
        run_ramp(d0 + 1, -1, 30);
        check("t3b_duty", int'(duty_out), 100);

        // Target equal to the present duty: immediate done, no ramp.
        d0 = done_cnt;
        request(100, 7, 1'b0);
        cyc();
        cyc();
        check("t4_done_cnt", done_cnt, d0 + 1);
        check("t4_duty", int'(duty_out), 100);
        check("t4_busy", int'(busy), 0);

        // Abort mid-ramp together with a new request.
        p0 = pop_cnt;
        request(0, 36, 1'b1);
        run_ramp(-1, p0 + 1, 10);
        check("t5_mid_duty", int'(duty_out), 64);
        sb.delete();
        push_e.duty   = 0;
        push_e.strobe = -1;
        sb.push_back(push_e);
        model_duty   = 0;
        d0           = done_cnt;
        abort        = 1'b1;
        target_valid = 1'b1;
        target_duty  = 9'd50;
        step_size    = 8'd10;
        cyc();
        check("t5_abort_duty", int'(duty_out), 0);
        check("t5_abort_ready", int'(target_ready), 0);
        check("t5_abort_busy", int'(busy), 0);
        strobe_period();
        check("t5_hold_duty", int'(duty_out), 0);
        abort        = 1'b0;
        target_valid = 1'b0;
        cyc();
        check("t5_ready_after", int'(target_ready), 1);
        check("t5_busy_after", int'(busy), 0);
        check("t5_no_done", done_cnt, d0);
        check("t5_sb_empty", sb.size(), 0);

        // Step of zero behaves as one; then reset mid-ramp.
        p0 = pop_cnt;
        request(3, 0, 1'b1);
        run_ramp(-1, p0 + 2, 20);
        check("t6_mid_duty", int'(duty_out), 2);
        period_strobe = 1'b1;
        strobe_cnt++;
        cyc();
        period_strobe = 1'b0;
        sb.delete();
        push_e.duty   = 0;
        push_e.strobe = -1;
        sb.push_back(push_e);
        model_duty   = 0;
        reset        = 1'b1;
        target_valid = 1'b1;
        target_duty  = 9'd200;
        cyc();
        check("t6_rst_duty", int'(duty_out), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        check("t6_rst_ready", int'(target_ready), 1);
        reset        = 1'b0;
        target_valid = 1'b0;
        cyc();
        check("t6_sb_empty", sb.size(), 0);

        // After reset a fresh ramp times from a cleared period counter.
        d0 = done_cnt;
        request(2, 1, 1'b1);
        run_ramp(d0 + 1, -1, 20);
        check("t6b_duty", int'(duty_out), 2);
        check("t6b_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
